// File: rtl/fu_branch_predictor_if.sv
// Signal bundle between the fetch stage, the branch unit and the BTB predictor.
interface fu_branch_predictor_if;
  logic [31:0] pc;
  logic        update_btb;
  logic [31:0] update_pc;
  logic        branch_outcome;
  logic [31:0] branch_target;
  logic        predicted_outcome;
  logic [31:0] predicted_target;

  modport bp (
    input  pc, update_btb, update_pc, branch_outcome, branch_target,
    output predicted_outcome, predicted_target
  );

  modport tb (
    output pc, update_btb, update_pc, branch_outcome, branch_target,
    input  predicted_outcome, predicted_target
  );
endinterface

// File: rtl/fu_branch_predictor_unit.sv
// Direct-mapped BTB with a 1-bit taken predictor per entry: combinational
// lookup on the fetch PC, one-cycle learning from resolved branches.
module fu_bp_btb_entry #(
  parameter int TAG_W = 26
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             wr_en,
  input  logic             clr_en,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      target
);
  always_ff @(posedge CLK or posedge nRST) begin
    if (nRST)        valid <= 1'b0;
    else if (wr_en)  valid <= 1'b1;
    else if (clr_en) valid <= 1'b0;
  end

  // Payload is only meaningful while valid, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (wr_en) begin
      tag    <= wr_tag;
      target <= wr_target;
    end
  end
endmodule

module fu_branch_predictor_unit #(
  parameter int BTB_ENTRIES = 16,
  parameter int IDX_W       = $clog2(BTB_ENTRIES),
  parameter int TAG_W       = 32 - IDX_W - 2
) (
  input  logic               CLK,
  input  logic               nRST,
  fu_branch_predictor_if.bp  fubpif
);
  logic [BTB_ENTRIES-1:0]            ent_valid;
  logic [BTB_ENTRIES-1:0][TAG_W-1:0] ent_tag;
  logic [BTB_ENTRIES-1:0][31:0]      ent_target;
  logic [BTB_ENTRIES-1:0]            wr_en;
  logic [BTB_ENTRIES-1:0]            clr_en;

  logic [IDX_W-1:0] rd_idx, upd_idx;
  logic [TAG_W-1:0] rd_tag, upd_tag;
  logic             hit;
  logic             unused_lsbs;

  assign rd_idx      = fubpif.pc[IDX_W+1:2];
  assign rd_tag      = fubpif.pc[31:IDX_W+2];
  assign upd_idx     = fubpif.update_pc[IDX_W+1:2];
  assign upd_tag     = fubpif.update_pc[31:IDX_W+2];
  assign unused_lsbs = ^{fubpif.pc[1:0], fubpif.update_pc[1:0]};

  genvar i;
  generate
    for (i = 0; i < BTB_ENTRIES; i++) begin : g_ent
      logic sel;
      assign sel       = fubpif.update_btb && (upd_idx == IDX_W'(i));
      // Taken always claims the slot; not-taken only retires our own tag.
      assign wr_en[i]  = sel && fubpif.branch_outcome;
      assign clr_en[i] = sel && !fubpif.branch_outcome && ent_valid[i] &&
                         (ent_tag[i] == upd_tag);

      fu_bp_btb_entry #(.TAG_W(TAG_W)) u_ent (
        .CLK       (CLK),
        .nRST      (nRST),
        .wr_en     (wr_en[i]),
        .clr_en    (clr_en[i]),
        .wr_tag    (upd_tag),
        .wr_target (fubpif.branch_target),
        .valid     (ent_valid[i]),
        .tag       (ent_tag[i]),
        .target    (ent_target[i])
      );
    end
  endgenerate

  assign hit = ent_valid[rd_idx] && (ent_tag[rd_idx] == rd_tag);

  always_comb begin
    fubpif.predicted_outcome = 1'b0;
    fubpif.predicted_target  = fubpif.pc + 32'd4;
    if (hit) begin
      fubpif.predicted_outcome = 1'b1;
      fubpif.predicted_target  = ent_target[rd_idx];
    end
  end
endmodule

// File: tb/tb_fu_branch_predictor_unit.sv
// Table-driven bench for the BTB predictor with a scoreboard of expected lookups.
module tb_fu_branch_predictor_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fu_branch_predictor_if fubpif ();

  fu_branch_predictor_unit dut (
    .CLK    (clk),
    .nRST   (rst),
    .fubpif (fubpif)
  );

  typedef struct {
    logic        upd;
    logic [31:0] upd_pc;
    logic        outc;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic        exp_o;
    logic [31:0] exp_t;
  } vec_t;

  typedef struct {
    logic        o;
    logic [31:0] t;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  vec_t vecs[20];

  task automatic push(input logic o, input logic [31:0] t, input string name);
    exp_t e;
    e.o = o; e.t = t; e.name = name;
    sb.push_back(e);
  endtask

  task automatic pop_check();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: no expected entry available");
    end else begin
      e = sb.pop_front();
      if (fubpif.predicted_outcome !== e.o || fubpif.predicted_target !== e.t) begin
        errors++;
        $display("FAIL %s: got outcome=%0b target=%08h, want outcome=%0b target=%08h",
                 e.name, fubpif.predicted_outcome, fubpif.predicted_target, e.o, e.t);
      end
    end
  endtask

  // Drive a lookup (no clock edge) and check it after settling.
  task automatic chk_now(input logic [31:0] pc, input logic o, input logic [31:0] t,
                         input string name);
    fubpif.pc = pc;
    push(o, t, name);
    #1;
    pop_check();
  endtask

  // One cycle: lookup + optional update; lookup sampled before the update edge.
  task automatic step(input vec_t v, input string name);
    @(posedge clk); #1;
    fubpif.update_btb     = v.upd;
    fubpif.update_pc      = v.upd_pc;
    fubpif.branch_outcome = v.outc;
    fubpif.branch_target  = v.tgt;
    fubpif.pc             = v.pc;
    push(v.exp_o, v.exp_t, name);
    @(negedge clk);
    pop_check();
  endtask

  initial begin
    //           upd   upd_pc         outc  tgt            pc             exp_o exp_t
    vecs[0]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h10,        1'b0, 32'h14};
    vecs[1]  = '{1'b1, 32'h10,        1'b1, 32'h08,        32'h10,        1'b0, 32'h14};
    vecs[2]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h10,        1'b1, 32'h08};
    vecs[3]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h20,        1'b0, 32'h24};
    vecs[4]  = '{1'b1, 32'h30,        1'b1, 32'h40,        32'h30,        1'b0, 32'h34};
    vecs[5]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h30,        1'b1, 32'h40};
    vecs[6]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h10,        1'b1, 32'h08};
    vecs[7]  = '{1'b1, 32'h10,        1'b0, 32'h08,        32'h13,        1'b1, 32'h08};
    vecs[8]  = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h10,        1'b0, 32'h14};
    vecs[9]  = '{1'b1, 32'h10,        1'b1, 32'h08,        32'h12,        1'b0, 32'h16};
    vecs[10] = '{1'b1, 32'h50,        1'b0, 32'h0,         32'h50,        1'b0, 32'h54};
    vecs[11] = '{1'b1, 32'h50,        1'b1, 32'h100,       32'h10,        1'b1, 32'h08};
    vecs[12] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h10,        1'b0, 32'h14};
    vecs[13] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h50,        1'b1, 32'h100};
    vecs[14] = '{1'b1, 32'hFFFFFFFC,  1'b1, 32'h1234,      32'hFFFFFFFC,  1'b0, 32'h0};
    vecs[15] = '{1'b1, 32'hFFFFFFFC,  1'b1, 32'h1234,      32'hFFFFFFFC,  1'b1, 32'h1234};
    vecs[16] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h3C,        1'b0, 32'h40};
    vecs[17] = '{1'b0, 32'h20,        1'b1, 32'h99,        32'h20,        1'b0, 32'h24};
    vecs[18] = '{1'b0, 32'h0,         1'b0, 32'h0,         32'h20,        1'b0, 32'h24};
    vecs[19] = '{1'b1, 32'h60,        1'b0, 32'h0,         32'h30,        1'b1, 32'h40};

    fubpif.pc = 32'h0; fubpif.update_btb = 1'b0; fubpif.update_pc = 32'h0;
    fubpif.branch_outcome = 1'b0; fubpif.branch_target = 32'h0;

    // Reset state, including an update strobed while reset is held.
    fubpif.update_btb = 1'b1; fubpif.update_pc = 32'h10;
    fubpif.branch_outcome = 1'b1; fubpif.branch_target = 32'h08;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_now(32'h10, 1'b0, 32'h14, "in_reset");
    fubpif.update_btb = 1'b0;
    rst = 1'b0;
    chk_now(32'h10, 1'b0, 32'h14, "after_reset_upd_dropped");

    for (int k = 0; k < 20; k++) step(vecs[k], $sformatf("vec%0d", k));

    // Mid-operation async reset clears every learned entry without an edge.
    @(negedge clk); #1;
    rst = 1'b1;
    chk_now(32'h30,       1'b0, 32'h34, "mid_rst_0x30");
    chk_now(32'h50,       1'b0, 32'h54, "mid_rst_0x50");
    chk_now(32'hFFFFFFFC, 1'b0, 32'h0,  "mid_rst_wrap");

    // Update coincident with reset across an edge is lost.
    fubpif.update_btb = 1'b1; fubpif.update_pc = 32'h20;
    fubpif.branch_outcome = 1'b1; fubpif.branch_target = 32'h77;
    @(posedge clk); #1;
    fubpif.update_btb = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    chk_now(32'h20, 1'b0, 32'h24, "rst_upd_dropped");

    // Relearn after reset works normally.
    step('{1'b1, 32'h20, 1'b1, 32'h77, 32'h20, 1'b0, 32'h24}, "relearn_pre");
    step('{1'b0, 32'h0,  1'b0, 32'h0,  32'h20, 1'b1, 32'h77}, "relearn_post");

    if (sb.size() != 0) begin
      errors++; checks++;
      $display("FAIL scoreboard_leftover: %0d entries left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
